pll_cfg_responder: RTL and testbench

Responder end of the PLL reconfiguration management port. It accepts the mode/start/fractional-M write sequence that the emu-level underclock controller issues on mgmt_clk, and stalls the initiator with mgmt_waitrequest while a reconfiguration runs. It models PLL relock and publishes the applied fractional value. It is the drop-in stub for targets without a reconfigurable PLL, and it is the bench model for the underclock sequencer.

---
 rtl/pll_cfg_responder.sv | 191 +++++++++++++++++++
 tb/tb_pll_cfg_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_responder.sv
// pll_cfg_responder
// Responder side of the PLL reconfiguration management port. It accepts
// MODE / FRAC / START writes, stalls the initiator with mgmt_waitrequest
// while the reconfiguration engine is busy, models PLL relock and publishes
// the fractional-M value that is currently applied. All outputs come
// straight from flops, so no input reaches an output combinationally.
`timescale 1ns/1ps

module pll_cfg_responder #(
  parameter int          BUSY_CYCLES   = 16,
  parameter int          RELOCK_CYCLES = 64,
  parameter logic [31:0] FRAC_DEFAULT  = 32'd3639383488
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_reset,
  input  logic        mgmt_write,
  input  logic        mgmt_read,
  input  logic [5:0]  mgmt_address,
  input  logic [31:0] mgmt_writedata,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic        locked,
  output logic [31:0] frac_active,
  output logic [7:0]  reconfig_count,
  output logic        err
);

  // Register map
  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_FRAC   = 6'd7;

  // Counters are loaded with N-1 on state entry and the state is left on
  // the edge that sees zero, so each state is occupied for exactly N cycles.
  localparam logic [7:0]  BUSY_LOAD   = 8'(BUSY_CYCLES - 1);
  localparam logic [15:0] RELOCK_LOAD = 16'(RELOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_RELOCK = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  busy_cnt_reg, busy_cnt_next;
  logic [15:0] relock_cnt_reg, relock_cnt_next;
  logic        mode_reg, mode_next;
  logic [31:0] frac_reg, frac_next;
  // FRAC captured at START; writes to FRAC after START wait for the next one
  logic [31:0] frac_snap_reg, frac_snap_next;
  logic [31:0] frac_active_reg, frac_active_next;
  logic [31:0] readdata_reg, readdata_next;
  logic        wait_reg, wait_next;
  logic        locked_reg, locked_next;
  logic [7:0]  count_reg, count_next;
  logic        err_reg, err_next;
  // Set while the power-up relock runs; that relock is not counted
  logic        powerup_reg, powerup_next;

  logic        wr_acc;
  logic        rd_acc;
  logic        start_req;

  assign mgmt_readdata    = readdata_reg;
  assign mgmt_waitrequest = wait_reg;
  assign locked           = locked_reg;
  assign frac_active      = frac_active_reg;
  assign reconfig_count   = count_reg;
  assign err              = err_reg;

  // Access qualification: a write always wins over a simultaneous read
  assign wr_acc = mgmt_write && !wait_reg;
  assign rd_acc = mgmt_read && !mgmt_write && !wait_reg;

  // State, register file and output flops; reset parks the FSM in RELOCK
  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      state_reg       <= ST_RELOCK;
      busy_cnt_reg    <= 8'd0;
      relock_cnt_reg  <= RELOCK_LOAD;
      mode_reg        <= 1'b0;
      frac_reg        <= FRAC_DEFAULT;
      frac_snap_reg   <= FRAC_DEFAULT;
      frac_active_reg <= FRAC_DEFAULT;
      readdata_reg    <= 32'd0;
      wait_reg        <= 1'b0;
      locked_reg      <= 1'b0;
      count_reg       <= 8'd0;
      err_reg         <= 1'b0;
      powerup_reg     <= 1'b1;
    end else begin
      state_reg       <= state_next;
      busy_cnt_reg    <= busy_cnt_next;
      relock_cnt_reg  <= relock_cnt_next;
      mode_reg        <= mode_next;
      frac_reg        <= frac_next;
      frac_snap_reg   <= frac_snap_next;
      frac_active_reg <= frac_active_next;
      readdata_reg    <= readdata_next;
      wait_reg        <= wait_next;
      locked_reg      <= locked_next;
      count_reg       <= count_next;
      err_reg         <= err_next;
      powerup_reg     <= powerup_next;
    end
  end

  // Register writes/reads, FSM sequencing and next values of every output
  always_comb begin
    state_next       = state_reg;
    busy_cnt_next    = busy_cnt_reg;
    relock_cnt_next  = relock_cnt_reg;
    mode_next        = mode_reg;
    frac_next        = frac_reg;
    frac_snap_next   = frac_snap_reg;
    frac_active_next = frac_active_reg;
    readdata_next    = readdata_reg;
    locked_next      = locked_reg;
    count_next       = count_reg;
    err_next         = err_reg;
    powerup_next     = powerup_reg;
    start_req        = 1'b0;

    // Write decode; STATUS is read-only so writes to it are simply dropped
    if (wr_acc) begin
      case (mgmt_address)
        ADDR_MODE:   mode_next = mgmt_writedata[0];
        ADDR_STATUS: ;
        ADDR_START: begin
          if (state_reg == ST_IDLE) begin
            start_req = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        ADDR_FRAC:   frac_next = mgmt_writedata;
        default:     err_next = 1'b1;
      endcase
    end

    // Read decode; STATUS reflects the state before this edge
    if (rd_acc) begin
      case (mgmt_address)
        ADDR_MODE:   readdata_next = {31'd0, mode_reg};
        ADDR_STATUS: readdata_next = {31'd0, (state_reg == ST_IDLE)};
        ADDR_FRAC:   readdata_next = frac_reg;
        default:     readdata_next = 32'd0;
      endcase
    end

    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          state_next     = ST_BUSY;
          busy_cnt_next  = BUSY_LOAD;
          frac_snap_next = frac_reg;
        end
      end
      ST_BUSY: begin
        if (busy_cnt_reg == 8'd0) begin
          state_next       = ST_RELOCK;
          relock_cnt_next  = RELOCK_LOAD;
          frac_active_next = frac_snap_reg;
          locked_next      = 1'b0;
        end else begin
          busy_cnt_next = busy_cnt_reg - 8'd1;
        end
      end
      ST_RELOCK: begin
        if (relock_cnt_reg == 16'd0) begin
          state_next   = ST_IDLE;
          locked_next  = 1'b1;
          powerup_next = 1'b0;
          if (!powerup_reg && (count_reg != 8'hFF)) begin
            count_next = count_reg + 8'd1;
          end
        end else begin
          relock_cnt_next = relock_cnt_reg - 16'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Stall only while BUSY in waitrequest mode; a MODE write applies at once
    wait_next = (state_next == ST_BUSY) && !mode_next;
  end

endmodule

// File: tb/tb_pll_cfg_responder.sv
// tb_pll_cfg_responder
// Directed bench for pll_cfg_responder with default parameters
// (16 busy cycles, 64 relock cycles). Inputs change 1 ns after a rising
// edge and outputs are sampled at the same point.
`timescale 1ns/1ps

module tb_pll_cfg_responder;

  localparam int          BUSY     = 16;
  localparam int          RELOCK   = 64;
  localparam logic [31:0] FRAC_DEF = 32'd3639383488;
  localparam logic [31:0] FRAC_NEW = 32'd3268298314;

  logic        mgmt_clk;
  logic        mgmt_reset;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic        locked;
  logic [31:0] frac_active;
  logic [7:0]  reconfig_count;
  logic        err;

  int checks = 0;
  int errors = 0;

  pll_cfg_responder #(
    .BUSY_CYCLES  (BUSY),
    .RELOCK_CYCLES(RELOCK),
    .FRAC_DEFAULT (FRAC_DEF)
  ) dut (
    .mgmt_clk        (mgmt_clk),
    .mgmt_reset      (mgmt_reset),
    .mgmt_write      (mgmt_write),
    .mgmt_read       (mgmt_read),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_readdata   (mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest),
    .locked          (locked),
    .frac_active     (frac_active),
    .reconfig_count  (reconfig_count),
    .err             (err)
  );

  initial mgmt_clk = 1'b0;
  always #5 mgmt_clk = ~mgmt_clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000 ns");
    $fatal(1);
  end

  // One write; waits (bounded) for waitrequest low, returns 1 ns after accept edge
  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    int guard;
    guard          = 0;
    mgmt_write     = 1'b1;
    mgmt_address   = a;
    mgmt_writedata = d;
    while (mgmt_waitrequest !== 1'b0 && guard < 1000) begin
      @(posedge mgmt_clk); #1;
      guard++;
    end
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%0d waitrequest=%b required 0", a, mgmt_waitrequest);
    end
    @(posedge mgmt_clk); #1;
    mgmt_write = 1'b0;
    $display("WR addr=%0d data=%0h", a, d);
  endtask

  // One read; returns the registered read data 1 ns after the accept edge
  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    int guard;
    guard        = 0;
    mgmt_read    = 1'b1;
    mgmt_address = a;
    while (mgmt_waitrequest !== 1'b0 && guard < 1000) begin
      @(posedge mgmt_clk); #1;
      guard++;
    end
    if (guard >= 1000) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%0d waitrequest=%b required 0", a, mgmt_waitrequest);
    end
    @(posedge mgmt_clk); #1;
    mgmt_read = 1'b0;
    d = mgmt_readdata;
    $display("RD addr=%0d data=%0h", a, d);
  endtask

  task automatic test_reset();
    logic exp_l;
    mgmt_reset     = 1'b1;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    repeat (3) @(posedge mgmt_clk);
    #1;
    checks++; if (mgmt_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait got %b expected 0", mgmt_waitrequest); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b expected 0", locked); end
    checks++; if (frac_active !== FRAC_DEF) begin errors++; $display("FAIL rst_frac got %0d expected %0d", frac_active, FRAC_DEF); end
    checks++; if (reconfig_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d expected 0", reconfig_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b expected 0", err); end
    checks++; if (mgmt_readdata !== 32'd0) begin errors++; $display("FAIL rst_readdata got %0h expected 0", mgmt_readdata); end
    mgmt_reset = 1'b0;
    for (int i = 1; i <= RELOCK; i++) begin
      @(posedge mgmt_clk); #1;
      exp_l = (i == RELOCK);
      checks++;
      if (locked !== exp_l) begin errors++; $display("FAIL powerup_locked edge=%0d got %b expected %b", i, locked, exp_l); end
    end
    checks++; if (reconfig_count !== 8'd0) begin errors++; $display("FAIL powerup_count got %0d expected 0", reconfig_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL powerup_err got %b expected 0", err); end
    $display("test_reset done");
  endtask

  task automatic test_waitrequest_mode();
    logic        exp_w, exp_l;
    logic [31:0] exp_f;
    bus_write(6'd0, 32'd0);
    bus_write(6'd7, FRAC_NEW);
    bus_write(6'd2, 32'd0);
    for (int k = 0; k <= BUSY + RELOCK; k++) begin
      if (k > 0) begin @(posedge mgmt_clk); #1; end
      exp_w = (k < BUSY);
      exp_l = (k < BUSY) || (k >= BUSY + RELOCK);
      exp_f = (k < BUSY) ? FRAC_DEF : FRAC_NEW;
      checks++; if (mgmt_waitrequest !== exp_w) begin errors++; $display("FAIL wr_mode_wait k=%0d got %b expected %b", k, mgmt_waitrequest, exp_w); end
      checks++; if (locked !== exp_l) begin errors++; $display("FAIL wr_mode_locked k=%0d got %b expected %b", k, locked, exp_l); end
      checks++; if (frac_active !== exp_f) begin errors++; $display("FAIL wr_mode_frac k=%0d got %0d expected %0d", k, frac_active, exp_f); end
    end
    checks++; if (reconfig_count !== 8'd1) begin errors++; $display("FAIL wr_mode_count got %0d expected 1", reconfig_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_mode_err got %b expected 0", err); end
    $display("test_waitrequest_mode done");
  endtask

  task automatic test_polling_mode();
    logic [31:0] exp_d;
    bus_write(6'd0, 32'd1);
    bus_write(6'd2, 32'd0);
    checks++; if (mgmt_waitrequest !== 1'b0) begin errors++; $display("FAIL poll_wait k=0 got %b expected 0", mgmt_waitrequest); end
    mgmt_read    = 1'b1;
    mgmt_address = 6'd1;
    for (int k = 1; k <= BUSY + RELOCK + 1; k++) begin
      @(posedge mgmt_clk); #1;
      exp_d = (k > BUSY + RELOCK) ? 32'd1 : 32'd0;
      checks++; if (mgmt_readdata !== exp_d) begin errors++; $display("FAIL poll_status k=%0d got %0h expected %0h", k, mgmt_readdata, exp_d); end
      checks++; if (mgmt_waitrequest !== 1'b0) begin errors++; $display("FAIL poll_wait k=%0d got %b expected 0", k, mgmt_waitrequest); end
    end
    mgmt_read = 1'b0;
    checks++; if (reconfig_count !== 8'd2) begin errors++; $display("FAIL poll_count got %0d expected 2", reconfig_count); end
    $display("test_polling_mode done");
  endtask

  task automatic test_polling_err_frac();
    logic [31:0] d;
    int          guard;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL perr_pre_err got %b expected 0", err); end
    bus_write(6'd7, 32'h1111_1111);
    bus_write(6'd2, 32'd0);                // START, k=0
    bus_write(6'd2, 32'd0);                // START during BUSY, k=1
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_err got %b expected 1", err); end
    checks++; if (mgmt_waitrequest !== 1'b0) begin errors++; $display("FAIL perr_wait got %b expected 0", mgmt_waitrequest); end
    bus_write(6'd7, 32'h2222_2222);        // FRAC during BUSY, k=2
    repeat (BUSY - 2) @(posedge mgmt_clk);
    #1;                                    // k=BUSY, RELOCK entered
    checks++; if (frac_active !== 32'h1111_1111) begin errors++; $display("FAIL perr_frac_relock got %0h expected 11111111", frac_active); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL perr_locked got %b expected 0", locked); end
    bus_write(6'd7, 32'h3333_3333);        // FRAC during RELOCK
    checks++; if (frac_active !== 32'h1111_1111) begin errors++; $display("FAIL perr_frac_hold got %0h expected 11111111", frac_active); end
    bus_read(6'd7, d);
    checks++; if (d !== 32'h3333_3333) begin errors++; $display("FAIL perr_frac_pending got %0h expected 33333333", d); end
    guard = 0;
    while (locked !== 1'b1 && guard < 200) begin @(posedge mgmt_clk); #1; guard++; end
    checks++; if (guard >= 200) begin errors++; $display("FAIL perr_lock_timeout locked=%b expected 1", locked); end
    checks++; if (reconfig_count !== 8'd3) begin errors++; $display("FAIL perr_count got %0d expected 3", reconfig_count); end
    checks++; if (frac_active !== 32'h1111_1111) begin errors++; $display("FAIL perr_frac_idle got %0h expected 11111111", frac_active); end
    bus_write(6'd2, 32'd0);                // next START applies pending FRAC
    repeat (BUSY) @(posedge mgmt_clk);
    #1;
    checks++; if (frac_active !== 32'h3333_3333) begin errors++; $display("FAIL perr_frac_next got %0h expected 33333333", frac_active); end
    guard = 0;
    while (locked !== 1'b1 && guard < 200) begin @(posedge mgmt_clk); #1; guard++; end
    checks++; if (guard >= 200) begin errors++; $display("FAIL perr_lock2_timeout locked=%b expected 1", locked); end
    checks++; if (reconfig_count !== 8'd4) begin errors++; $display("FAIL perr_count2 got %0d expected 4", reconfig_count); end
    $display("test_polling_err_frac done");
  endtask

  task automatic test_reset_mid_busy();
    logic exp_l;
    bus_write(6'd0, 32'd0);
    bus_write(6'd2, 32'd0);
    repeat (5) @(posedge mgmt_clk);
    #1;
    checks++; if (mgmt_waitrequest !== 1'b1) begin errors++; $display("FAIL mid_wait_busy got %b expected 1", mgmt_waitrequest); end
    mgmt_reset = 1'b1;
    #1;
    checks++; if (mgmt_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_wait got %b expected 0", mgmt_waitrequest); end
    checks++; if (frac_active !== FRAC_DEF) begin errors++; $display("FAIL mid_frac got %0d expected %0d", frac_active, FRAC_DEF); end
    checks++; if (reconfig_count !== 8'd0) begin errors++; $display("FAIL mid_count got %0d expected 0", reconfig_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err got %b expected 0", err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_locked got %b expected 0", locked); end
    checks++; if (mgmt_readdata !== 32'd0) begin errors++; $display("FAIL mid_readdata got %0h expected 0", mgmt_readdata); end
    @(posedge mgmt_clk); #1;
    mgmt_reset = 1'b0;
    for (int i = 1; i <= RELOCK; i++) begin
      @(posedge mgmt_clk); #1;
      exp_l = (i == RELOCK);
      checks++;
      if (locked !== exp_l) begin errors++; $display("FAIL mid_relock edge=%0d got %b expected %b", i, locked, exp_l); end
    end
    checks++; if (reconfig_count !== 8'd0) begin errors++; $display("FAIL mid_count_after got %0d expected 0", reconfig_count); end
    $display("test_reset_mid_busy done");
  endtask

  task automatic test_unknown_addr();
    logic [31:0] d;
    bus_write(6'd5, 32'hDEAD_BEEF);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL unk_err got %b expected 1", err); end
    bus_write(6'd7, 32'h0BAD_F00D);
    bus_read(6'd7, d);
    checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL unk_read_frac got %0h expected 0badf00d", d); end
    checks++; if (frac_active !== FRAC_DEF) begin errors++; $display("FAIL unk_frac_active got %0d expected %0d", frac_active, FRAC_DEF); end
    bus_read(6'd3, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unk_read3 got %0h expected 0", d); end
    bus_read(6'd1, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL unk_status got %0h expected 1", d); end
    bus_read(6'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unk_mode got %0h expected 0", d); end
    @(posedge mgmt_clk); #1;
    checks++; if (mgmt_readdata !== 32'd0) begin errors++; $display("FAIL unk_hold got %0h expected 0", mgmt_readdata); end
    // write and read together: write lands, read is dropped
    mgmt_write     = 1'b1;
    mgmt_read      = 1'b1;
    mgmt_address   = 6'd7;
    mgmt_writedata = 32'h1234_5678;
    @(posedge mgmt_clk); #1;
    mgmt_write = 1'b0;
    mgmt_read  = 1'b0;
    checks++; if (mgmt_readdata !== 32'd0) begin errors++; $display("FAIL wr_rd_drop got %0h expected 0", mgmt_readdata); end
    // back-to-back reads, one per cycle
    mgmt_read    = 1'b1;
    mgmt_address = 6'd7;
    @(posedge mgmt_clk); #1;
    checks++; if (mgmt_readdata !== 32'h1234_5678) begin errors++; $display("FAIL b2b_frac got %0h expected 12345678", mgmt_readdata); end
    mgmt_address = 6'd1;
    @(posedge mgmt_clk); #1;
    checks++; if (mgmt_readdata !== 32'd1) begin errors++; $display("FAIL b2b_status got %0h expected 1", mgmt_readdata); end
    mgmt_address = 6'd63;
    @(posedge mgmt_clk); #1;
    checks++; if (mgmt_readdata !== 32'd0) begin errors++; $display("FAIL b2b_unknown got %0h expected 0", mgmt_readdata); end
    mgmt_read = 1'b0;
    $display("test_unknown_addr done");
  endtask

  initial begin
    test_reset();
    test_waitrequest_mode();
    test_polling_mode();
    test_polling_err_frac();
    test_reset_mid_busy();
    test_unknown_addr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
